rsvp_collector: RTL and testbench
=================================

# rsvp_collector

Sequential front end that produces the attendance flags consumed by the two-group party-decision logic. It accepts RSVP messages over a valid/ready handshake during a fixed collection window. It drives registered H1/H2/B1/B2 flags and, at window close, registers the decision P = (H1|H2)&(B1|B2) with a Done indication.

## Interface
- WINDOW, 16: collection window length in clock cycles; legal range 1..255.
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  begin a collection round; sampled only in IDLE and DONE.
- MsgValid  input  1  RSVP message present.
- MsgReady  output  1  collector accepting messages; high only in COLLECT.
- MsgId  input  2  target flag: 0=H1, 1=H2, 2=B1, 3=B2.
- MsgAttend  input  1  value written to the target flag (1 = attending, 0 = withdraw).
- H1, H2, B1, B2  output  1 each  registered attendance flags.
- Count  output  4  accepted messages this round, saturating at 15.
- P  output  1  registered party decision.
- Done  output  1  high in DONE.
- Busy  output  1  high in COLLECT or DECIDE.

## Operation
- Reset (Rst_n=0, asynchronous): state=IDLE; H1/H2/B1/B2=0, Count=0, P=0, Done=0, Busy=0, MsgReady=0, window counter=0.
- FSM states: IDLE, COLLECT, DECIDE, DONE.
- IDLE: Start=1 clears flags, Count and P; loads the window counter with WINDOW-1; next state COLLECT.
- COLLECT: MsgReady=1. A message is accepted when MsgValid&MsgReady; then flag[MsgId] <= MsgAttend and Count increments unless it is 15. The window counter decrements every cycle. When the counter is 0, that cycle still accepts, and the next state is DECIDE.
- Repeated messages to the same MsgId: the last accepted value wins.
- DECIDE: one cycle. P <= (H1|H2)&(B1|B2) using the registered flags, which include any acceptance from the final COLLECT cycle. Next state DONE.
- DONE: Done=1; flags, Count and P hold. Start=1 behaves exactly as in IDLE (clear, reload, go to COLLECT).
- Start in COLLECT or DECIDE is ignored. MsgValid outside COLLECT is ignored and causes no state change.
- Reset mid-round aborts immediately to the reset values; no partial decision is retained.

## Timing
- Start sampled at edge 0 moves the FSM to COLLECT from edge 0 to edge WINDOW, giving exactly WINDOW accept cycles.
- DECIDE occupies the cycle after edge WINDOW. P and Done become visible after edge WINDOW+1.
- Flag and Count update are visible one cycle after the accepting edge.
- MsgReady is a decode of the state register only; it has no combinational path from MsgValid.
- Back-to-back messages are accepted on every COLLECT cycle (throughput of 1 per cycle).

## Configuration
- RSVP_EARLY_CLOSE_EN defined: in COLLECT, if the registered flags already satisfy (H1|H2)&(B1|B2), the next state is DECIDE regardless of the window counter. A message accepted in that same cycle is still applied.
- Without the macro: the window always runs the full WINDOW cycles.

## Test plan
- Reset check: assert Rst_n=0 mid-COLLECT -> all outputs return to 0 immediately, and state returns to IDLE.
- WINDOW=16, Start, then messages (0,1) and (3,1) -> after the window H1=1, B2=1, Count=2, P=1, and Done rises 17 cycles after the Start edge.
- Messages (0,1), (1,1) only -> P=0, Done=1, Count=2.
- Message (2,1) followed by (2,0), plus (0,1) -> B1=0, P=0. This confirms last-write-wins.
- Message accepted on the final COLLECT cycle (cycle 16) -> it is included in P; MsgValid held high in DECIDE and DONE -> no acceptance, and Count is unchanged.
- With RSVP_EARLY_CLOSE_EN: messages (1,1) at cycle 2 and (2,1) at cycle 3 -> DECIDE at cycle 5 and P=1; without the macro the same stimulus gives DECIDE at cycle 17.

Source files
------------

// File: rtl/rsvp_collector.sv
// RSVP collector: gathers H1/H2/B1/B2 attendance over a fixed window, then registers P=(H1|H2)&(B1|B2).
// Optional RSVP_EARLY_CLOSE_EN: leave the window as soon as the registered flags already satisfy P.
module rsvp_collector #(
  parameter int WINDOW = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [1:0] msg_id,
  input  logic       msg_attend,
  output logic       h1,
  output logic       h2,
  output logic       b1,
  output logic       b2,
  output logic [3:0] count,
  output logic       p,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DECIDE, S_DONE} state_t;

  localparam logic [7:0] WIN_LOAD = 8'(WINDOW - 1);

  state_t     state_reg, state_next;
  logic [7:0] win_cnt_reg;
  logic [3:0] flags_reg;
  logic [3:0] count_reg;
  logic       p_reg;
  logic       accept, load, decision, close;

  assign accept   = (state_reg == S_COLLECT) && msg_valid;
  assign load     = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign decision = (flags_reg[0] | flags_reg[1]) & (flags_reg[2] | flags_reg[3]);

`ifdef RSVP_EARLY_CLOSE_EN
  assign close = (win_cnt_reg == 8'd0) || decision;
`else
  assign close = (win_cnt_reg == 8'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = S_COLLECT;
      S_COLLECT:      if (close) state_next = S_DECIDE;
      S_DECIDE:       state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                 win_cnt_reg <= 8'd0;
    else if (load)                                              win_cnt_reg <= WIN_LOAD;
    else if ((state_reg == S_COLLECT) && (win_cnt_reg != 8'd0)) win_cnt_reg <= win_cnt_reg - 8'd1;
  end

  // One register per flag; a later acceptance to the same id simply overwrites.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             flags_reg[gi] <= 1'b0;
        else if (load)                          flags_reg[gi] <= 1'b0;
        else if (accept && (msg_id == 2'(gi)))  flags_reg[gi] <= msg_attend;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             count_reg <= 4'd0;
    else if (load)                          count_reg <= 4'd0;
    else if (accept && (count_reg != 4'hF)) count_reg <= count_reg + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       p_reg <= 1'b0;
    else if (load)                    p_reg <= 1'b0;
    else if (state_reg == S_DECIDE)   p_reg <= decision;
  end

  assign msg_ready = (state_reg == S_COLLECT);
  assign busy      = (state_reg == S_COLLECT) || (state_reg == S_DECIDE);
  assign done      = (state_reg == S_DONE);
  assign h1        = flags_reg[0];
  assign h2        = flags_reg[1];
  assign b1        = flags_reg[2];
  assign b2        = flags_reg[3];
  assign count     = count_reg;
  assign p         = p_reg;

endmodule

// File: tb/tb_rsvp_collector.sv
// Self-checking bench for rsvp_collector: directed rounds with literal expectations,
// then randomized traffic compared every cycle against a round-level behavioural model.
module tb_rsvp_collector;

  localparam int W = 16;
`ifdef RSVP_EARLY_CLOSE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, msg_valid, msg_ready, msg_attend;
  logic [1:0] msg_id;
  logic       h1, h2, b1, b2, p, done, busy;
  logic [3:0] count;

  int checks = 0;
  int fails  = 0;

  rsvp_collector #(.WINDOW(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_id(msg_id), .msg_attend(msg_attend), .h1(h1), .h2(h2), .b1(b1), .b2(b2),
    .count(count), .p(p), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0=idle 1=collecting 2=deciding 3=done; m_left = collect cycles remaining.
  int         m_phase, m_left, m_count;
  logic [3:0] m_flag;
  logic       m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_left <= 0; m_count <= 0; m_flag <= 4'b0; m_p <= 1'b0;
    end else begin
      case (m_phase)
        0, 3: if (start) begin
          m_phase <= 1; m_left <= W; m_count <= 0; m_flag <= 4'b0; m_p <= 1'b0;
        end
        1: begin
          if (msg_valid) begin
            m_flag[msg_id] <= msg_attend;
            m_count <= (m_count < 15) ? m_count + 1 : 15;
          end
          m_left <= m_left - 1;
          if (m_left == 1 || (EARLY && (m_flag[0] | m_flag[1]) && (m_flag[2] | m_flag[3])))
            m_phase <= 2;
        end
        default: begin
          m_p     <= (m_flag[0] | m_flag[1]) & (m_flag[2] | m_flag[3]);
          m_phase <= 3;
        end
      endcase
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [11:0] act, exp;
    act = {msg_ready, busy, done, p, count, b2, b1, h2, h1};
    exp = {m_phase == 1, (m_phase == 1) || (m_phase == 2), m_phase == 3, m_p, 4'(m_count), m_flag};
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model_cmp t=%0t: got %h expected %h", $time, act, exp);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else
      $display("ok   %s = %0d", name, act);
  endtask

  logic [W:0]     plan_v;
  logic [2*W+1:0] plan_id;
  logic [W:0]     plan_a;

  task automatic clear_plan();
    plan_v = '0; plan_id = '0; plan_a = '0;
  endtask

  task automatic add_msg(input int c, input logic [1:0] id, input logic a);
    plan_v[c] = 1'b1; plan_id[2*c +: 2] = id; plan_a[c] = a;
  endtask

  // Runs one round from the Start edge (edge 0); lat = edge after which done is seen,
  // decide_at = cycle number (cycle n+1 follows edge n) in which DECIDE is observed.
  task automatic do_round(input logic hold, output int lat, output int decide_at);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; decide_at = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      if (n <= W) begin
        msg_valid = plan_v[n]; msg_id = plan_id[2*n +: 2]; msg_attend = plan_a[n];
      end else begin
        msg_valid = hold; msg_id = 2'($urandom); msg_attend = 1'($urandom);
      end
      @(negedge clk);
      if (busy && !msg_ready && decide_at < 0) decide_at = n + 1;
      if (done) lat = n;
    end
    $display("round: lat=%0d decide_at=%0d h1=%0d h2=%0d b1=%0d b2=%0d count=%0d p=%0d",
             lat, decide_at, h1, h2, b1, b2, count, p);
  endtask

  initial begin
    int lat, dec;
    rst_n = 1'b0; start = 1'b0; msg_valid = 1'b0; msg_id = 2'd0; msg_attend = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({msg_ready, busy, done, p, count, b2, b1, h2, h1}), 0);
    rst_n = 1'b1;
    msg_valid = 1'b1;
    @(negedge clk);
    chk("idle_ignores_valid", int'({msg_ready, busy, done, count}), 0);
    msg_valid = 1'b0;

    // H1 and B2 attend -> party.
    clear_plan(); add_msg(2, 2'd0, 1'b1); add_msg(5, 2'd3, 1'b1);
    do_round(1'b0, lat, dec);
    chk("s1_h1", h1, 1); chk("s1_b2", b2, 1); chk("s1_count", count, 2);
    chk("s1_p", p, 1); chk("s1_done_lat", lat, EARLY ? 7 : 17);

    // Only hosts -> no party.
    clear_plan(); add_msg(1, 2'd0, 1'b1); add_msg(7, 2'd1, 1'b1);
    do_round(1'b0, lat, dec);
    chk("s2_p", p, 0); chk("s2_done", done, 1); chk("s2_count", count, 2);

    // Withdrawal overrides earlier attend.
    clear_plan(); add_msg(1, 2'd2, 1'b1); add_msg(3, 2'd2, 1'b0); add_msg(4, 2'd0, 1'b1);
    do_round(1'b0, lat, dec);
    chk("s3_b1", b1, 0); chk("s3_p", p, 0); chk("s3_count", count, 3);

    // Final-cycle acceptance counts; valid held through DECIDE/DONE is ignored.
    clear_plan(); add_msg(3, 2'd0, 1'b1); add_msg(16, 2'd2, 1'b1);
    do_round(1'b1, lat, dec);
    repeat (3) @(negedge clk);
    msg_valid = 1'b0;
    chk("s4_p", p, 1); chk("s4_b1", b1, 1); chk("s4_count_hold", count, 2);
    chk("s4_done", done, 1); chk("s4_decide_at", dec, 17);

    // Early-close stimulus.
    clear_plan(); add_msg(2, 2'd1, 1'b1); add_msg(3, 2'd2, 1'b1);
    do_round(1'b0, lat, dec);
    chk("s5_decide_at", dec, EARLY ? 5 : 17); chk("s5_p", p, 1);

    // Asynchronous reset in the middle of collecting.
    clear_plan(); add_msg(1, 2'd0, 1'b1); add_msg(2, 2'd3, 1'b1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    msg_valid = 1'b1; msg_id = 2'd0; msg_attend = 1'b1;
    repeat (2) @(negedge clk);
    msg_id = 2'd3;
    @(negedge clk);
    msg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({msg_ready, busy, done, p, count, b2, b1, h2, h1}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_reset_idle", int'({msg_ready, busy, done}), 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("restart_ready", msg_ready, 1);

    // Randomized traffic, including Start during collection and one async reset pulse.
    for (int i = 0; i < 800; i++) begin
      start      = ($urandom_range(0, 9) == 0);
      msg_valid  = 1'($urandom);
      msg_id     = 2'($urandom);
      msg_attend = ($urandom_range(0, 3) != 0);
      if (i == 400) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
